// File: rtl/wait_state_memory_if.sv
// Request/response bus between the CPU sequencer and the wait-state memory.
// The master drives the address, write data and level strobes; the memory drives busy, read data, valid and error.
interface wait_state_memory_if #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 10
);

   logic [ADDR_W-1:0] Memadr;
   logic [DATA_W-1:0] memdata_w;
   logic              memrd;
   logic              memwrt;
   logic              membusy;
   logic [DATA_W-1:0] memdata_r;
   logic              memvalid;
   logic              memerr;

   modport master (
      output Memadr,
      output memdata_w,
      output memrd,
      output memwrt,
      input  membusy,
      input  memdata_r,
      input  memvalid,
      input  memerr
   );

   modport slave (
      input  Memadr,
      input  memdata_w,
      input  memrd,
      input  memwrt,
      output membusy,
      output memdata_r,
      output memvalid,
      output memerr
   );

endinterface

// File: rtl/wait_state_memory.sv
// Handshaked word memory with programmable wait states, a one-cycle read-valid
// strobe and out-of-range address detection.
module wait_state_memory #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 10,
   parameter int DEPTH  = 512,
   parameter int WAIT   = 2
) (
   input logic                clock,
   input logic                reset,
   wait_state_memory_if.slave bus
);

   typedef enum logic [2:0] {
      M_IDLE,
      M_WAIT,
      M_XFER,
      M_HOLD,
      M_DONE
   } state_t;

   localparam int              IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);
   localparam logic [3:0]      WAIT_L  = 4'(WAIT);

   state_t            state_q, state_d;
   logic [3:0]        count_q, count_d;
   logic [ADDR_W-1:0] adr_q, adr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic              isRead_q, isRead_d;
   logic              busy_q, busy_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic              valid_q, valid_d;
   logic              err_q, err_d;

   logic              request;
   logic              inRange;
   logic              strobe;
   logic [IDX_W-1:0]  idx;

   logic [DATA_W-1:0] mem [DEPTH];

   // A read wins when both strobes are high, so the held strobe follows the captured op.
   assign request = bus.memrd || bus.memwrt;
   assign inRange = ({1'b0, adr_q} < DEPTH_L);
   assign idx     = adr_q[IDX_W-1:0];
   assign strobe  = isRead_q ? bus.memrd : bus.memwrt;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q  <= M_IDLE;
         count_q  <= 4'd0;
         adr_q    <= '0;
         wdata_q  <= '0;
         isRead_q <= 1'b0;
         busy_q   <= 1'b0;
         rdata_q  <= '0;
         valid_q  <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         count_q  <= count_d;
         adr_q    <= adr_d;
         wdata_q  <= wdata_d;
         isRead_q <= isRead_d;
         busy_q   <= busy_d;
         rdata_q  <= rdata_d;
         valid_q  <= valid_d;
         err_q    <= err_d;
      end
   end

   always_comb begin
      state_d = state_q;
      count_d = count_q;
      case (state_q)
         M_IDLE: begin
            if (request) begin
               count_d = WAIT_L;
               state_d = (WAIT_L == 4'd0) ? M_XFER : M_WAIT;
            end
         end
         M_WAIT: begin
            count_d = count_q - 4'd1;
            if (count_q <= 4'd1) begin
               state_d = M_XFER;
            end
         end
         M_XFER: state_d = M_HOLD;
         M_HOLD: begin
            if (!strobe) begin
               state_d = M_DONE;
            end
         end
         M_DONE: state_d = M_IDLE;
         default: state_d = M_IDLE;
      endcase
   end

   // Output registers hold their value except where a state updates them.
   always_comb begin
      adr_d    = adr_q;
      wdata_d  = wdata_q;
      isRead_d = isRead_q;
      busy_d   = busy_q;
      rdata_d  = rdata_q;
      valid_d  = 1'b0;
      err_d    = err_q;
      case (state_q)
         M_IDLE: begin
            if (request) begin
               adr_d    = bus.Memadr;
               wdata_d  = bus.memdata_w;
               isRead_d = bus.memrd;
               busy_d   = 1'b1;
               err_d    = 1'b0;
            end
         end
         M_XFER: begin
            err_d = !inRange;
            if (isRead_q) begin
               valid_d = 1'b1;
               rdata_d = inRange ? mem[idx] : '0;
            end
         end
         M_DONE: busy_d = 1'b0;
         default: ;
      endcase
   end

   // The store array has no reset; contents survive a reset pulse.
   always_ff @(posedge clock) begin
      if (state_q == M_XFER && !isRead_q && inRange) begin
         mem[idx] <= wdata_q;
      end
   end

   assign bus.membusy   = busy_q;
   assign bus.memdata_r = rdata_q;
   assign bus.memvalid  = valid_q;
   assign bus.memerr    = err_q;

endmodule

// File: tb/tb_wait_state_memory.sv
// Bench for wait_state_memory: three instances (WAIT = 2, 5, 0) checked every cycle
// against a transaction-level model, plus directed literal checks.
module tb_wait_state_memory;

   localparam int NDUT = 3;

   logic        clock;
   logic        rstS   [NDUT];
   logic        rdS    [NDUT];
   logic        wrS    [NDUT];
   logic [9:0]  adrS   [NDUT];
   logic [15:0] wdS    [NDUT];
   logic        busyS  [NDUT];
   logic        validS [NDUT];
   logic        errS   [NDUT];
   logic [15:0] rdataS [NDUT];

   int assertCount = 0;
   int failCount   = 0;

   int resBusy     [NDUT];
   int resValidCyc [NDUT];
   int resValidCnt [NDUT];
   int resErr0     [NDUT];

   function automatic int waitOf(input int i);
      return (i == 0) ? 2 : ((i == 1) ? 5 : 0);
   endfunction

   for (genvar g = 0; g < NDUT; g++) begin : gDut
      wait_state_memory_if #(.DATA_W(16), .ADDR_W(10)) bus ();

      assign bus.Memadr    = adrS[g];
      assign bus.memdata_w = wdS[g];
      assign bus.memrd     = rdS[g];
      assign bus.memwrt    = wrS[g];
      assign busyS[g]      = bus.membusy;
      assign validS[g]     = bus.memvalid;
      assign errS[g]       = bus.memerr;
      assign rdataS[g]     = bus.memdata_r;

      wait_state_memory #(
         .DATA_W(16),
         .ADDR_W(10),
         .DEPTH (512),
         .WAIT  ((g == 0) ? 2 : ((g == 1) ? 5 : 0))
      ) dut (
         .clock(clock),
         .reset(rstS[g]),
         .bus  (bus)
      );
   end

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic checkOutput(input string name, input int i, input logic [31:0] got, input logic [31:0] exp);
      assertCount++;
      if (got !== exp) begin
         failCount++;
         $display("[TB] FAIL %s dut%0d: got %h, expected %h at %0t", name, i, got, exp, $time);
      end
   endtask

   // Transaction-level model: each accepted request is tracked by the number of
   // edges since acceptance, and outputs follow the edge-numbered timing rules.
   bit          mAct       [NDUT];
   int          mK         [NDUT];
   bit          mOpRd      [NDUT];
   int          mAdr       [NDUT];
   logic [15:0] mDat       [NDUT];
   int          mRelK      [NDUT];
   bit          mExpBusy   [NDUT];
   bit          mExpValid  [NDUT];
   bit          mExpErr    [NDUT];
   logic [15:0] mExpData   [NDUT];
   bit          mDataKnown [NDUT];
   logic [15:0] mMem       [NDUT][1024];
   bit          mKnown     [NDUT][1024];

   always @(posedge clock) begin
      for (int i = 0; i < NDUT; i++) begin
         if (rstS[i]) begin
            mAct[i]       = 1'b0;
            mExpBusy[i]   = 1'b0;
            mExpValid[i]  = 1'b0;
            mExpErr[i]    = 1'b0;
            mExpData[i]   = 16'h0000;
            mDataKnown[i] = 1'b1;
         end else if (!mAct[i]) begin
            mExpValid[i] = 1'b0;
            if (rdS[i] || wrS[i]) begin
               mAct[i]     = 1'b1;
               mK[i]       = 0;
               mOpRd[i]    = rdS[i];
               mAdr[i]     = int'(adrS[i]);
               mDat[i]     = wdS[i];
               mRelK[i]    = -1;
               mExpBusy[i] = 1'b1;
               mExpErr[i]  = 1'b0;
            end
         end else begin
            mK[i]++;
            mExpValid[i] = 1'b0;
            if (mK[i] == waitOf(i) + 1) begin
               mExpErr[i] = (mAdr[i] >= 512);
               if (mOpRd[i]) begin
                  mExpValid[i] = 1'b1;
                  if (mAdr[i] < 512) begin
                     mExpData[i]   = mMem[i][mAdr[i]];
                     mDataKnown[i] = mKnown[i][mAdr[i]];
                  end else begin
                     mExpData[i]   = 16'h0000;
                     mDataKnown[i] = 1'b1;
                  end
               end else if (mAdr[i] < 512) begin
                  mMem[i][mAdr[i]]   = mDat[i];
                  mKnown[i][mAdr[i]] = 1'b1;
               end
            end else if (mK[i] >= waitOf(i) + 2) begin
               if (mRelK[i] < 0) begin
                  if (!(mOpRd[i] ? rdS[i] : wrS[i])) mRelK[i] = mK[i];
               end else if (mK[i] == mRelK[i] + 1) begin
                  mExpBusy[i] = 1'b0;
                  mAct[i]     = 1'b0;
               end
            end
         end
      end
   end

   // Every cycle, away from the active edge, compare each instance with the model.
   always @(negedge clock) begin
      for (int i = 0; i < NDUT; i++) begin
         checkOutput("membusy", i, 32'(busyS[i]), 32'(mExpBusy[i]));
         checkOutput("memvalid", i, 32'(validS[i]), 32'(mExpValid[i]));
         checkOutput("memerr", i, 32'(errS[i]), 32'(mExpErr[i]));
         if (mDataKnown[i]) checkOutput("memdata_r", i, 32'(rdataS[i]), 32'(mExpData[i]));
      end
   end

   // One request: strobes held for 'hold' edges, then waits (bounded) for busy to drop.
   task automatic applyStimulus(input int i, input bit r, input bit w, input int a, input int d, input int hold);
      bit done;
      @(negedge clock);
      rdS[i]  = r;
      wrS[i]  = w;
      adrS[i] = 10'(a);
      wdS[i]  = 16'(d);
      resBusy[i]     = 0;
      resValidCyc[i] = -1;
      resValidCnt[i] = 0;
      resErr0[i]     = -1;
      done = 1'b0;
      for (int n = 0; n < 200; n++) begin
         @(negedge clock);
         if (n + 1 == hold) begin
            rdS[i] = 1'b0;
            wrS[i] = 1'b0;
         end
         if (n == 0) resErr0[i] = int'(errS[i]);
         if (busyS[i]) resBusy[i]++;
         if (validS[i]) begin
            resValidCnt[i]++;
            resValidCyc[i] = n;
         end
         if (!busyS[i]) begin
            done = 1'b1;
            break;
         end
      end
      rdS[i] = 1'b0;
      wrS[i] = 1'b0;
      checkOutput("busyTimeout", i, 32'(done), 32'd1);
   endtask

   task automatic randomReset(input int i);
      @(negedge clock);
      rdS[i]  = 1'($urandom_range(0, 1));
      wrS[i]  = 1'b1;
      adrS[i] = 10'($urandom_range(0, 15));
      wdS[i]  = 16'($urandom);
      repeat ($urandom_range(0, 8)) @(negedge clock);
      rdS[i] = 1'b0;
      wrS[i] = 1'b0;
      #2 rstS[i] = 1'b1;
      #1 checkOutput("asyncReset", i, 32'({busyS[i], validS[i], errS[i], rdataS[i]}), 32'd0);
      @(negedge clock);
      rstS[i] = 1'b0;
   endtask

   function automatic int randAddr();
      if ($urandom_range(0, 7) == 0) return $urandom_range(512, 1023);
      return $urandom_range(0, 15);
   endfunction

   task automatic randomRun(input int i);
      int kind;
      int hold;
      for (int t = 0; t < 150; t++) begin
         if ($urandom_range(0, 19) == 0) begin
            randomReset(i);
         end else begin
            kind = $urandom_range(0, 9);
            hold = ($urandom_range(0, 4) == 0) ? $urandom_range(4, 12) : $urandom_range(1, 3);
            applyStimulus(i, kind < 4 || kind >= 8, kind >= 4, randAddr(), $urandom_range(0, 65535), hold);
         end
         repeat ($urandom_range(0, 2)) @(negedge clock);
      end
   endtask

   initial begin
      for (int i = 0; i < NDUT; i++) begin
         rstS[i] = 1'b1;
         rdS[i]  = 1'b0;
         wrS[i]  = 1'b0;
         adrS[i] = '0;
         wdS[i]  = '0;
      end
      repeat (2) @(negedge clock);
      for (int i = 0; i < NDUT; i++) begin
         checkOutput("resetState", i, 32'({busyS[i], validS[i], errS[i], rdataS[i]}), 32'd0);
         rstS[i] = 1'b0;
      end

      $display("[TB] directed checks, WAIT=2");
      applyStimulus(0, 1'b0, 1'b1, 'h005, 'hBEEF, 1);
      checkOutput("wrBusyCycles", 0, resBusy[0], 5);
      checkOutput("wrValidCount", 0, resValidCnt[0], 0);
      applyStimulus(0, 1'b1, 1'b0, 'h005, 0, 1);
      checkOutput("rdBusyCycles", 0, resBusy[0], 5);
      checkOutput("rdValidCycle", 0, resValidCyc[0], 3);
      checkOutput("rdValidCount", 0, resValidCnt[0], 1);
      checkOutput("rdData", 0, 32'(rdataS[0]), 32'h0000BEEF);
      checkOutput("rdErr", 0, 32'(errS[0]), 32'd0);

      applyStimulus(0, 1'b0, 1'b1, 'h010, 'h1111, 1);
      applyStimulus(0, 1'b1, 1'b1, 'h010, 'h2222, 1);
      checkOutput("bothRdData", 0, 32'(rdataS[0]), 32'h00001111);
      applyStimulus(0, 1'b1, 1'b0, 'h010, 0, 1);
      checkOutput("bothWriteDropped", 0, 32'(rdataS[0]), 32'h00001111);

      applyStimulus(0, 1'b0, 1'b1, 88, 'h5A5A, 1);
      applyStimulus(0, 1'b0, 1'b1, 600, 'h1234, 1);
      checkOutput("oorWrErr", 0, 32'(errS[0]), 32'd1);
      applyStimulus(0, 1'b1, 1'b0, 600, 0, 1);
      checkOutput("oorRdData", 0, 32'(rdataS[0]), 32'd0);
      checkOutput("oorRdValidCount", 0, resValidCnt[0], 1);
      checkOutput("oorRdErr", 0, 32'(errS[0]), 32'd1);
      applyStimulus(0, 1'b1, 1'b0, 88, 0, 1);
      checkOutput("oorErrClearAtAccept", 0, resErr0[0], 0);
      checkOutput("oorNoAlias", 0, 32'(rdataS[0]), 32'h00005A5A);

      applyStimulus(0, 1'b1, 1'b0, 'h005, 0, 10);
      checkOutput("longBusyCycles", 0, resBusy[0], 11);
      checkOutput("longValidCount", 0, resValidCnt[0], 1);
      checkOutput("longData", 0, 32'(rdataS[0]), 32'h0000BEEF);

      $display("[TB] directed checks, WAIT=5 reset mid-write");
      applyStimulus(1, 1'b0, 1'b1, 7, 'hAAAA, 1);
      checkOutput("w5BusyCycles", 1, resBusy[1], 8);
      @(negedge clock);
      wrS[1]  = 1'b1;
      adrS[1] = 10'd7;
      wdS[1]  = 16'h5555;
      @(negedge clock);
      wrS[1] = 1'b0;
      repeat (2) @(negedge clock);
      checkOutput("busyBeforeRst", 1, 32'(busyS[1]), 32'd1);
      #2 rstS[1] = 1'b1;
      #1 checkOutput("midRstOutputs", 1, 32'({busyS[1], validS[1], errS[1], rdataS[1]}), 32'd0);
      @(negedge clock);
      rstS[1] = 1'b0;
      applyStimulus(1, 1'b1, 1'b0, 7, 0, 1);
      checkOutput("rstWriteNotCommitted", 1, 32'(rdataS[1]), 32'h0000AAAA);
      checkOutput("w5ValidCycle", 1, resValidCyc[1], 6);

      $display("[TB] directed checks, WAIT=0");
      applyStimulus(2, 1'b0, 1'b1, 3, 'h0F0F, 1);
      checkOutput("w0WrBusyCycles", 2, resBusy[2], 3);
      applyStimulus(2, 1'b1, 1'b0, 3, 0, 1);
      checkOutput("w0RdBusyCycles", 2, resBusy[2], 3);
      checkOutput("w0ValidCycle", 2, resValidCyc[2], 1);
      checkOutput("w0RdData", 2, 32'(rdataS[2]), 32'h00000F0F);

      $display("[TB] randomized traffic on all instances");
      fork
         randomRun(0);
         randomRun(1);
         randomRun(2);
      join

      repeat (3) @(negedge clock);
      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
